// File: rtl/instr_fetch_buffer_if.sv
// Fetch-buffer bus: CPU fetch handshake plus the memory instruction-port burst signals.
// The buffer uses the slave modport; the fetch stage and the memory responder drive the master side.
interface instr_fetch_buffer_if #(
  parameter int W = 32
);
  logic          cpu_req;
  logic [31:0]   cpu_adr;
  logic          cpu_rdy;
  logic          cpu_val;
  logic [W-1:0]  cpu_data;
  logic          flush;
  logic          instrreq;
  logic [31:0]   instradr;
  logic          instrval;
  logic [W-1:0]  instr;

  modport slave (
    input  cpu_req, cpu_adr, flush, instrval, instr,
    output cpu_rdy, cpu_val, cpu_data, instrreq, instradr
  );

  modport master (
    output cpu_req, cpu_adr, flush, instrval, instr,
    input  cpu_rdy, cpu_val, cpu_data, instrreq, instradr
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Single-line (8-word) instruction fetch buffer; misses refill the line with an 8-beat burst.
// Optional EARLY_RESTART_EN: answer the miss as soon as the wanted beat arrives.
module instr_fetch_buffer #(
  parameter int BEATS = 8,
  parameter int W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_buffer_if.slave  bus
);
  typedef enum logic {IDLE, FILL} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_line [BEATS];
  logic [26:0]   r_tag;
  logic          r_valid;
  logic [2:0]    r_beat;
  logic          r_flush_pend;
  logic [2:0]    r_want;
  logic          r_cpu_val;
  logic [W-1:0]  r_cpu_data;
  logic          r_instrreq;
  logic [31:0]   r_instradr;

  logic          w_accept;
  logic          w_hit;
  logic          w_cap;
  logic          w_last;
  logic          w_unused;

  assign w_accept = bus.cpu_req && (r_state == IDLE);
  assign w_hit    = r_valid && (r_tag == bus.cpu_adr[31:5]);
  assign w_cap    = (r_state == FILL) && bus.instrval;
  assign w_last   = w_cap && (r_beat == 3'(BEATS - 1));
  assign w_unused = ^bus.cpu_adr[1:0];

  assign bus.cpu_rdy  = (r_state == IDLE);
  assign bus.cpu_val  = r_cpu_val;
  assign bus.cpu_data = r_cpu_data;
  assign bus.instrreq = r_instrreq;
  assign bus.instradr = r_instradr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == IDLE) begin
      if (w_accept && !w_hit) begin
        w_state_next = FILL;
      end
    end else begin
      if (w_last) begin
        w_state_next = IDLE;
      end
    end
  end

  // Line storage is write-only during FILL; beats arriving in IDLE never land here.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_line[r_beat] <= bus.instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag        <= '0;
      r_valid      <= 1'b0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_want       <= '0;
      r_cpu_val    <= 1'b0;
      r_cpu_data   <= '0;
      r_instrreq   <= 1'b0;
      r_instradr   <= '0;
    end else if (r_state == IDLE) begin
      r_cpu_val <= 1'b0;
      // Lookup uses the pre-flush valid; flush then clears it on the same edge.
      if (bus.flush) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_hit) begin
          r_cpu_val  <= 1'b1;
          r_cpu_data <= r_line[bus.cpu_adr[4:2]];
        end else begin
          r_instrreq <= 1'b1;
          r_instradr <= {bus.cpu_adr[31:5], 5'b0};
          r_tag      <= bus.cpu_adr[31:5];
          r_want     <= bus.cpu_adr[4:2];
          r_valid    <= 1'b0;
          r_beat     <= '0;
        end
      end
    end else begin
      r_cpu_val <= 1'b0;
      // The burst always runs to completion so the responder's counter stays in step.
      if (bus.flush) begin
        r_flush_pend <= 1'b1;
      end
      if (w_cap) begin
        r_beat <= r_beat + 3'd1;
`ifdef EARLY_RESTART_EN
        if (r_beat == r_want) begin
          r_cpu_val  <= 1'b1;
          r_cpu_data <= bus.instr;
        end
`endif
        if (w_last) begin
          r_instrreq   <= 1'b0;
          r_valid      <= !r_flush_pend && !bus.flush;
          r_flush_pend <= 1'b0;
`ifndef EARLY_RESTART_EN
          r_cpu_val  <= 1'b1;
          r_cpu_data <= (r_want == 3'(BEATS - 1)) ? bus.instr : r_line[r_want];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: burst responder (word at byte address A = A),
// a cycle-level request/response model compared every cycle, and literal spot checks.
module tb_instr_fetch_buffer;
`ifdef EARLY_RESTART_EN
  localparam bit ER = 1'b1;
`else
  localparam bit ER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inj_val = 1'b0;
  logic [31:0] inj_data = '0;
  logic        rsp_val;
  logic [31:0] rsp_data;
  logic [31:0] rsp_base;
  int          rsp_cnt;
  int          checks = 0;
  int          passed = 0;

  instr_fetch_buffer_if #(.W(32)) bus ();

  instr_fetch_buffer #(.BEATS(8), .W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.instrval = rsp_val | inj_val;
  assign bus.instr    = inj_val ? inj_data : rsp_data;

  // Memory responder: counter starts on the first edge it sees instrreq, data beats E2..E9.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_cnt  <= 0;
      rsp_val  <= 1'b0;
      rsp_data <= '0;
      rsp_base <= '0;
    end else if (rsp_cnt == 9) begin
      rsp_cnt <= 0;
      rsp_val <= 1'b0;
    end else if (rsp_cnt != 0 || bus.instrreq) begin
      if (rsp_cnt == 0) rsp_base <= bus.instradr;
      rsp_cnt <= rsp_cnt + 1;
      if (rsp_cnt >= 1) begin
        rsp_val  <= 1'b1;
        rsp_data <= rsp_base + 32'(4 * (rsp_cnt - 1));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Model: which line is valid, when a fill window runs, and when each answer is due.
  int          n = 0;
  int          n0 = -100;
  bit          m_valid = 1'b0;
  bit          m_fill_valid = 1'b0;
  logic [26:0] m_tag = '0;
  logic [31:0] m_base = '0;
  int          resp_cyc[$];
  logic [31:0] resp_dat[$];

  always @(negedge clk) begin
    bit busy;
    bit exp_val;
    n++;
    if (!reset) begin
      m_valid = 1'b0;
      n0 = -100;
      resp_cyc.delete();
      resp_dat.delete();
    end else begin
      busy    = (n > n0) && (n <= n0 + 10);
      exp_val = (resp_cyc.size() > 0) && (resp_cyc[0] == n);
      chk("cpu_rdy", 32'(bus.cpu_rdy), 32'(!busy));
      chk("instrreq", 32'(bus.instrreq), 32'(busy));
      if (busy) chk("instradr", bus.instradr, m_base);
      chk("cpu_val", 32'(bus.cpu_val), 32'(exp_val));
      if (exp_val) begin
        chk("cpu_data", bus.cpu_data, resp_dat[0]);
        void'(resp_cyc.pop_front());
        void'(resp_dat.pop_front());
      end
      if (!busy) begin
        if (bus.cpu_req) begin
          if (m_valid && m_tag == bus.cpu_adr[31:5]) begin
            resp_cyc.push_back(n + 1);
          end else begin
            n0           = n;
            m_fill_valid = 1'b1;
            m_valid      = 1'b0;
            m_tag        = bus.cpu_adr[31:5];
            m_base       = {bus.cpu_adr[31:5], 5'b0};
            resp_cyc.push_back(ER ? n + 4 + int'(bus.cpu_adr[4:2]) : n + 11);
          end
          resp_dat.push_back({bus.cpu_adr[31:2], 2'b00});
        end
        if (bus.flush) m_valid = 1'b0;
      end else begin
        if (bus.flush) m_fill_valid = 1'b0;
        if (n == n0 + 10) m_valid = m_fill_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then observe ncyc cycles after the accept edge.
  task automatic run_req(input logic [31:0] adr, input int ncyc, input int flush_at,
                         output int val_idx, output logic [31:0] val_dat, output int pulses,
                         output int req_cnt, output int rdy_low, output int rdy_idx,
                         output logic [31:0] first_adr);
    val_idx = 0; val_dat = '0; pulses = 0; req_cnt = 0; rdy_low = 0; rdy_idx = 0;
    first_adr = '0;
    step();
    bus.cpu_req = 1'b1;
    bus.cpu_adr = adr;
    for (int i = 1; i <= ncyc; i++) begin
      step();
      if (i == 1) first_adr = bus.instradr;
      if (bus.instrreq) req_cnt++;
      if (!bus.cpu_rdy) rdy_low++;
      if (bus.cpu_rdy && rdy_idx == 0) rdy_idx = i;
      if (bus.cpu_val) begin
        pulses++;
        val_idx = i;
        val_dat = bus.cpu_data;
      end
      bus.cpu_req = 1'b0;
      bus.flush   = (i == flush_at);
    end
    bus.flush = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          vi, pc, rc, rl, ri;
    logic [31:0] vd, fa;
    bus.cpu_req = 1'b0;
    bus.cpu_adr = '0;
    bus.flush   = 1'b0;
    repeat (3) step();
    chk("rst_cpu_val", 32'(bus.cpu_val), 32'd0);
    chk("rst_cpu_data", bus.cpu_data, 32'd0);
    chk("rst_instrreq", 32'(bus.instrreq), 32'd0);
    chk("rst_instradr", bus.instradr, 32'd0);
    chk("rst_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    reset = 1'b1;
    step();

    run_req(32'h44, 12, 0, vi, vd, pc, rc, rl, ri, fa);
    $display("cold miss 0x44: val@%0d data=0x%0h req_cycles=%0d", vi, vd, rc);
    chk("cold_instradr", fa, 32'h40);
    chk("cold_req_cycles", 32'(rc), 32'd10);
    chk("cold_rdy_low", 32'(rl), 32'd10);
    chk("cold_rdy_back", 32'(ri), 32'd11);
    chk("cold_pulses", 32'(pc), 32'd1);
    chk("cold_val_idx", 32'(vi), ER ? 32'd5 : 32'd11);
    chk("cold_data", vd, 32'h44);

    step();
    bus.cpu_req = 1'b1; bus.cpu_adr = 32'h40;
    step();
    chk("hit0_val", 32'(bus.cpu_val), 32'd1); chk("hit0_data", bus.cpu_data, 32'h40);
    bus.cpu_adr = 32'h48;
    step();
    chk("hit1_val", 32'(bus.cpu_val), 32'd1); chk("hit1_data", bus.cpu_data, 32'h48);
    bus.cpu_adr = 32'h5C;
    step();
    chk("hit2_val", 32'(bus.cpu_val), 32'd1); chk("hit2_data", bus.cpu_data, 32'h5C);
    chk("hit_instrreq", 32'(bus.instrreq), 32'd0);
    bus.cpu_req = 1'b0;
    $display("hits 0x40/0x48/0x5C done");

    run_req(32'h60, 12, 6, vi, vd, pc, rc, rl, ri, fa);
    $display("miss 0x60 with flush: val@%0d data=0x%0h", vi, vd);
    chk("flush_pulses", 32'(pc), 32'd1);
    chk("flush_data", vd, 32'h60);
    run_req(32'h64, 12, 0, vi, vd, pc, rc, rl, ri, fa);
    $display("after flush 0x64: req_cycles=%0d data=0x%0h", rc, vd);
    chk("postflush_req_cycles", 32'(rc), 32'd10);
    chk("postflush_data", vd, 32'h64);

    step();
    bus.cpu_req = 1'b1; bus.cpu_adr = 32'h80;
    for (int i = 1; i <= 8; i++) begin
      step();
      bus.cpu_req = 1'b0;
    end
    #1 reset = 1'b0;
    #1;
    chk("midrst_instrreq", 32'(bus.instrreq), 32'd0);
    chk("midrst_cpu_val", 32'(bus.cpu_val), 32'd0);
    chk("midrst_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    step();
    step();
    reset = 1'b1;
    run_req(32'h84, 12, 0, vi, vd, pc, rc, rl, ri, fa);
    $display("after reset 0x84: req_cycles=%0d data=0x%0h", rc, vd);
    chk("postrst_req_cycles", 32'(rc), 32'd10);
    chk("postrst_data", vd, 32'h84);

    step();
    inj_val = 1'b1; inj_data = 32'hDEADBEEF;
    step();
    chk("idle_instrval_val", 32'(bus.cpu_val), 32'd0);
    step();
    chk("idle_instrval_val2", 32'(bus.cpu_val), 32'd0);
    inj_val = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_adr = 32'h80;
    step();
    chk("idle_hit0_data", bus.cpu_data, 32'h80);
    bus.cpu_adr = 32'h9C;
    step();
    chk("idle_hit7_data", bus.cpu_data, 32'h9C);
    bus.cpu_req = 1'b0;
    $display("idle instrval pulse: line intact");

    run_req(32'h68, 14, 0, vi, vd, pc, rc, rl, ri, fa);
    $display("miss 0x68: val@%0d pulses=%0d data=0x%0h rdy@%0d", vi, pc, vd, ri);
    chk("m68_val_idx", 32'(vi), ER ? 32'd6 : 32'd11);
    chk("m68_pulses", 32'(pc), 32'd1);
    chk("m68_data", vd, 32'h68);
    chk("m68_rdy_back", 32'(ri), 32'd11);

    step();
    bus.cpu_req = 1'b1; bus.cpu_adr = 32'h6C; bus.flush = 1'b1;
    step();
    chk("flushhit_val", 32'(bus.cpu_val), 32'd1);
    chk("flushhit_data", bus.cpu_data, 32'h6C);
    bus.cpu_adr = 32'h60; bus.flush = 1'b0;
    step();
    chk("flushhit_then_miss", 32'(bus.instrreq), 32'd1);
    bus.cpu_req = 1'b0;
    $display("flush+hit 0x6C then miss 0x60");
    repeat (14) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
